// File: rtl/fe_diag_pkg.sv
// fe_diag_pkg
// Shared types for the front-end diagnostic sequencer and the benches that
// drive it: the queued command record, the sequencer state encoding, the
// CLK diagnostic function codes and the tick-timer expiry helper.
// Field vectors are declared descending; the MSB corresponds to bit 0 in
// EBUS numbering (func[6] is ds[0], data[35] is EBUS data bit 0).
package fe_diag_pkg;

  localparam int TIMER_W = 16;

  typedef struct packed {
    logic        read;
    logic [6:0]  func;
    logic [35:0] data;
  } tDiagCmd;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER
  } tDiagSeqState;

  // CLK diagnostic functions used by the master reset sequence.
  typedef enum logic [6:0] {
    CLK_STOP       = 7'o000,
    CLK_START      = 7'o001,
    CLK_STEP       = 7'o002,
    CLK_CLR_RESET  = 7'o006,
    CLK_SET_RESET  = 7'o007,
    CLK_LD_SOURCE  = 7'o042,
    CLK_LD_RATE    = 7'o043,
    CLK_LD_MISC    = 7'o044,
    CLK_LD_SYNC    = 7'o046,
    CLK_LD_PARITY  = 7'o051,
    CLK_LD_BURST   = 7'o052
  } tClkFunc;

  // A phase is over when its count is already zero (zero-length phase) or
  // when the final tick of a non-zero count arrives this cycle.
  function automatic logic timer_expired(input logic [TIMER_W-1:0] timer,
                                         input logic               tick);
    return (timer == '0) || (tick && (timer == TIMER_W'(1)));
  endfunction

endpackage

// File: rtl/fe_diag_fifo.sv
// fe_diag_fifo
// Synchronous command FIFO of tDiagCmd records with show-ahead read port.
// Ports: clk/rst (async, active-high), push/pop requests (ignored when
// full/empty), flush (empties, wins over push/pop), wr_data, rd_data (head),
// full, empty, count (occupancy).
module fe_diag_fifo
  import fe_diag_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  tDiagCmd                wr_data,
  output tDiagCmd                rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  tDiagCmd     mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/fe_diag_sequencer.sv
// fe_diag_sequencer
// Queues diagnostic function requests and plays each one onto the EBUS
// diagnostic lines as SETUP -> STROBE -> RECOVER, paced by 'tick'. Read
// functions capture EBUS data on the last strobe tick and present it on the
// response port; an unaccepted response holds the sequencer in RECOVER.
// Ports: clk/CROBAR (async, active-high reset); tick pacing enable; abort;
// cmdValid/cmdReady/cmdRead/cmdFunc/cmdData command push; rspValid/rspReady/
// rspData/rspFunc read response; ebusDataIn EBUS data; ds/diagStrobe/dataOut/
// dataDrive EBUS drive; busy and count status.
module fe_diag_sequencer
  import fe_diag_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int SETUP_TICKS   = 1,
  parameter int STROBE_TICKS  = 9,
  parameter int RECOVER_TICKS = 4
) (
  input  logic                   clk,
  input  logic                   CROBAR,
  input  logic                   tick,
  input  logic                   abort,
  input  logic                   cmdValid,
  output logic                   cmdReady,
  input  logic                   cmdRead,
  input  logic [6:0]             cmdFunc,
  input  logic [35:0]            cmdData,
  output logic                   rspValid,
  input  logic                   rspReady,
  output logic [35:0]            rspData,
  output logic [6:0]             rspFunc,
  input  logic [35:0]            ebusDataIn,
  output logic [6:0]             ds,
  output logic                   diagStrobe,
  output logic [35:0]            dataOut,
  output logic                   dataDrive,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam logic [TIMER_W-1:0] SETUP_LOAD   = TIMER_W'(SETUP_TICKS);
  localparam logic [TIMER_W-1:0] STROBE_LOAD  = TIMER_W'(STROBE_TICKS);
  localparam logic [TIMER_W-1:0] RECOVER_LOAD = TIMER_W'(RECOVER_TICKS);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  tDiagSeqState       state_q, state_nxt;
  logic [TIMER_W-1:0] timer_q, timer_nxt;
  tDiagCmd            work_q, work_nxt, head, push_cmd;
  logic               fifo_full, fifo_empty;
  logic               push, pop, load, capture, expired;
  logic [6:0]         ds_nxt;
  logic [35:0]        data_nxt;
  logic               strobe_nxt, drive_nxt;

  // A push coinciding with abort is dropped along with the flushed queue.
  assign push     = cmdValid && !fifo_full && !abort;
  assign push_cmd = {cmdRead, cmdFunc, cmdData};
  assign expired  = timer_expired(timer_q, tick);

  fe_diag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (CROBAR),
    .push    (push),
    .pop     (pop),
    .flush   (abort),
    .wr_data (push_cmd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign cmdReady = !fifo_full;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);

  // State, timer and working command register.
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
      work_q  <= work_nxt;
    end
  end

  // Next-state logic. The head stays in the FIFO until its strobe ends so
  // that count reflects every command not yet strobed.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    pop       = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    if (abort) begin
      state_nxt = ST_RECOVER;
      timer_nxt = RECOVER_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_nxt = ST_SETUP;
            timer_nxt = SETUP_LOAD;
            load      = 1'b1;
          end
        end
        ST_SETUP: begin
          if (expired) begin
            state_nxt = ST_STROBE;
            timer_nxt = STROBE_LOAD;
          end else if (tick) begin
            timer_nxt = timer_q - TIMER_ONE;
          end
        end
        ST_STROBE: begin
          if (expired) begin
            state_nxt = ST_RECOVER;
            timer_nxt = RECOVER_LOAD;
            pop       = 1'b1;
            capture   = work_q.read;
          end else if (tick) begin
            timer_nxt = timer_q - TIMER_ONE;
          end
        end
        ST_RECOVER: begin
          // Keep counting while stalled on a pending response.
          if (expired && !rspValid) begin
            state_nxt = ST_IDLE;
          end else if (tick && (timer_q != '0)) begin
            timer_nxt = timer_q - TIMER_ONE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    work_nxt = load ? head : work_q;
  end

  // EBUS drive values follow the state being entered so the registered
  // outputs switch on the same edge as the state.
  always_comb begin
    ds_nxt     = '0;
    data_nxt   = '0;
    strobe_nxt = 1'b0;
    drive_nxt  = 1'b0;
    if ((state_nxt == ST_SETUP) || (state_nxt == ST_STROBE)) begin
      ds_nxt     = work_nxt.func;
      data_nxt   = work_nxt.read ? 36'd0 : work_nxt.data;
      drive_nxt  = !work_nxt.read;
      strobe_nxt = (state_nxt == ST_STROBE);
    end
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      ds         <= '0;
      dataOut    <= '0;
      diagStrobe <= 1'b0;
      dataDrive  <= 1'b0;
    end else begin
      ds         <= ds_nxt;
      dataOut    <= data_nxt;
      diagStrobe <= strobe_nxt;
      dataDrive  <= drive_nxt;
    end
  end

  // Response register; a capture can only occur once the previous response
  // has been accepted, because RECOVER cannot exit while it is pending.
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      rspValid <= 1'b0;
      rspData  <= '0;
      rspFunc  <= '0;
    end else if (capture) begin
      rspValid <= 1'b1;
      rspData  <= ebusDataIn;
      rspFunc  <= work_q.func;
    end else if (rspValid && rspReady) begin
      rspValid <= 1'b0;
    end
  end

endmodule
